// File: rtl/gol_run_sequencer_if.sv
// Host-side bit-serial streams of gol_run_sequencer: load (in_*) and unload (out_*).
// The sequencer takes the slave modport; the host takes the master modport.
interface gol_run_sequencer_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/gol_run_sequencer.sv
// Load / step / unload sequencer for the N-cell Game-of-Life grid engine.
// Defining POP_COUNT_EN adds o_pop_count: the number of live cells seen during unload.
module gol_run_sequencer #(
  parameter int unsigned N        = 25,
  parameter int unsigned GEN_W    = 8,
  parameter int unsigned STEP_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [GEN_W-1:0]       i_cfg_gens,
  gol_run_sequencer_if.slave     bus,
  output logic                   o_grid_shift_en,
  output logic                   o_grid_shift_in,
  input  logic                   i_grid_shift_out,
  output logic                   o_grid_step,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [GEN_W-1:0]       o_gens_left
`ifdef POP_COUNT_EN
  ,
  output logic [$clog2(N+1)-1:0] o_pop_count
`endif
);

  localparam int unsigned CellW   = $clog2(N + 1);
  localparam int unsigned GapLast = (STEP_GAP > 0) ? STEP_GAP - 1 : 0;
  localparam int unsigned GapW    = (GapLast > 0) ? $clog2(GapLast + 1) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StStep, StGap, StUnload, StDone} state_e;

  state_e           r_state;
  logic [CellW-1:0] r_cell;
  logic [GapW-1:0]  r_gap;
  logic [GEN_W-1:0] r_gens;

  logic w_load_hs;
  logic w_unload_hs;
  logic w_last_cell;

  // Abort suppresses any handshake in its cycle so the grid is never shifted by it.
  assign w_load_hs   = (r_state == StLoad) && bus.in_valid && !i_abort;
  assign w_unload_hs = (r_state == StUnload) && bus.out_ready && !i_abort;
  assign w_last_cell = (r_cell == CellW'(N - 1));

  assign bus.in_ready    = (r_state == StLoad);
  assign bus.out_valid   = (r_state == StUnload);
  assign bus.out_data    = bus.out_valid && i_grid_shift_out;
  assign o_grid_shift_en = w_load_hs || w_unload_hs;
  // Unload feeds the tail back to the head so the pattern survives a full read-out.
  assign o_grid_shift_in = (w_load_hs && bus.in_data) || (w_unload_hs && i_grid_shift_out);
  assign o_grid_step     = (r_state == StStep);
  assign o_busy          = (r_state != StIdle);
  assign o_done          = (r_state == StDone);
  assign o_gens_left     = r_gens;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cell  <= '0;
      r_gap   <= '0;
      r_gens  <= '0;
    end else if (i_abort) begin
      r_state <= StIdle;
      r_cell  <= '0;
      r_gap   <= '0;
      r_gens  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_gens  <= i_cfg_gens;
            r_cell  <= '0;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (w_load_hs) begin
            if (w_last_cell) begin
              r_cell  <= '0;
              r_state <= (r_gens != '0) ? StStep : StUnload;
            end else begin
              r_cell <= r_cell + CellW'(1);
            end
          end
        end
        StStep: begin
          r_gens <= r_gens - GEN_W'(1);
          r_gap  <= '0;
          if (STEP_GAP != 0) begin
            r_state <= StGap;
          end else begin
            r_state <= (r_gens > GEN_W'(1)) ? StStep : StUnload;
          end
        end
        StGap: begin
          if (r_gap == GapW'(GapLast)) begin
            r_gap   <= '0;
            r_state <= (r_gens != '0) ? StStep : StUnload;
          end else begin
            r_gap <= r_gap + GapW'(1);
          end
        end
        StUnload: begin
          if (w_unload_hs) begin
            if (w_last_cell) begin
              r_cell  <= '0;
              r_state <= StDone;
            end else begin
              r_cell <= r_cell + CellW'(1);
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef POP_COUNT_EN
  logic [CellW-1:0] r_pop;

  // Nothing counts between start and UNLOAD, so clearing on start equals clearing on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop <= '0;
    end else if ((r_state == StIdle) && i_start && !i_abort) begin
      r_pop <= '0;
    end else if (w_unload_hs && i_grid_shift_out) begin
      r_pop <= r_pop + CellW'(1);
    end
  end

  assign o_pop_count = r_pop;
`endif

endmodule

// File: tb/tb_gol_run_sequencer.sv
// Self-checking bench for gol_run_sequencer: a behavioural 5x5 grid engine plus a
// Game-of-Life reference drive randomized load/unload traffic.
module tb_gol_run_sequencer;
  localparam int N        = 25;
  localparam int SIDE     = 5;
  localparam int GEN_W    = 8;
  localparam int STEP_GAP = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [GEN_W-1:0] cfg_gens;
  logic             shift_en;
  logic             shift_in;
  logic             shift_out;
  logic             step;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gens_left;
`ifdef POP_COUNT_EN
  logic [$clog2(N+1)-1:0] pop_count;
`endif

  gol_run_sequencer_if bus ();

  gol_run_sequencer #(
    .N        (N),
    .GEN_W    (GEN_W),
    .STEP_GAP (STEP_GAP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_cfg_gens       (cfg_gens),
    .bus              (bus),
    .o_grid_shift_en  (shift_en),
    .o_grid_shift_in  (shift_in),
    .i_grid_shift_out (shift_out),
    .o_grid_step      (step),
    .o_busy           (busy),
    .o_done           (done),
    .o_gens_left      (gens_left)
`ifdef POP_COUNT_EN
    ,
    .o_pop_count      (pop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference rules on a cell-indexed vector (bit i = cell i, row-major, dead border).
  function automatic logic [N-1:0] gol(input logic [N-1:0] c);
    logic [N-1:0] nx;
    int n;
    for (int r = 0; r < SIDE; r++) begin
      for (int k = 0; k < SIDE; k++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dk = -1; dk <= 1; dk++)
            if ((dr != 0 || dk != 0) && r + dr >= 0 && r + dr < SIDE && k + dk >= 0 &&
                k + dk < SIDE)
              n += int'(c[(r + dr) * SIDE + k + dk]);
        nx[r * SIDE + k] = (n == 3) || (c[r * SIDE + k] && n == 2);
      end
    end
    return nx;
  endfunction

  function automatic logic [N-1:0] gol_n(input logic [N-1:0] c, input int gens);
    logic [N-1:0] v;
    v = c;
    for (int g = 0; g < gens; g++) v = gol(v);
    return v;
  endfunction

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] o;
    for (int i = 0; i < N; i++) o[i] = v[N-1-i];
    return o;
  endfunction

  function automatic logic [N-1:0] rand_pat();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = 1'($urandom_range(1));
    return p;
  endfunction

  // Grid engine model: head at chain[0], tail at chain[N-1]; cell i sits at chain[N-1-i].
  logic [N-1:0] chain;
  always @(posedge clk) begin
    if (shift_en) chain <= {chain[N-2:0], shift_in};
    else if (step) chain <= rev(gol(rev(chain)));
  end
  assign shift_out = chain[N-1];

  // Observations of the most recent run.
  logic [N-1:0]     got;
  int               n_load, n_unload, n_done, shift_viol, stall_viol, unload_t;
  logic [GEN_W-1:0] unload_gens;
  bit               timed_out, aborted, done_busy, ab_busy, ab_port;
  logic [GEN_W-1:0] ab_gens;
  int               step_q[$];
  logic [GEN_W-1:0] stepg_q[$];

  // amode: 0 none, 1 abort in the cycle after the first step pulse, 2 abort after 10 unloads.
  task automatic run_seq(input logic [N-1:0] pat, input logic [GEN_W-1:0] gens,
                         input int vpct, input int rpct, input int amode);
    int li, ui;
    bit stalled, pdata, hin, hout, fin, do_abort;
    step_q.delete();
    stepg_q.delete();
    got = '0; n_done = 0; shift_viol = 0; stall_viol = 0; unload_t = -1; unload_gens = '0;
    timed_out = 0; aborted = 0; done_busy = 0; fin = 0; do_abort = 0;
    li = 0; ui = 0; stalled = 0; pdata = 0;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_gens = gens;
    for (int t = 0; t < 4000 && !fin; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (aborted) begin
        abort   = 1'b0;
        ab_busy = busy;
        ab_gens = gens_left;
        ab_port = bus.in_ready | bus.out_valid | done;
        fin     = 1;
      end else begin
        bus.in_valid  = !do_abort && li < N && ($urandom_range(99) < vpct);
        bus.in_data   = bus.in_valid ? pat[li] : 1'b0;
        bus.out_ready = !do_abort && ($urandom_range(99) < rpct);
        abort         = do_abort;
        #1;
        hin  = bus.in_valid && bus.in_ready;
        hout = bus.out_valid && bus.out_ready;
        if (shift_en !== (hin || hout)) shift_viol++;
        if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== pdata)) stall_viol++;
        stalled = bus.out_valid && !bus.out_ready;
        pdata   = bus.out_data;
        if (step) begin
          step_q.push_back(cyc);
          stepg_q.push_back(gens_left);
        end
        if (bus.out_valid && unload_t < 0) begin
          unload_t    = cyc;
          unload_gens = gens_left;
        end
        if (hin) li++;
        if (hout) begin
          got[ui] = bus.out_data;
          ui++;
        end
        if (done) begin
          n_done++;
          done_busy = busy;
          fin = (amode == 0);
        end
        if (do_abort) aborted = 1;
        do_abort = (amode == 1 && step && step_q.size() == 1) ||
                   (amode == 2 && hout && ui == 10);
      end
    end
    if (!fin) timed_out = 1;
    n_load = li;
    n_unload = ui;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, shift_en, shift_in, step, busy, done,
         gens_left} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b/%b/%b/%0d want all zero",
               bus.in_ready, bus.out_valid, bus.out_data, shift_en, shift_in, step, busy, done,
               gens_left);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_idle_ready: got %b want 0", bus.in_ready);
    end
  endtask

  task automatic test_zero_gens();
    logic [N-1:0] pat;
    for (int i = 0; i < N; i++) pat[i] = (i % 2 == 0);
    for (int pass = 0; pass < 2; pass++) begin
      run_seq(pat, '0, 100, 100, 0);
      total++;
      if (timed_out) begin bad++; $display("FAIL zero_timeout: got timeout want done"); end
      total++;
      if (got !== pat) begin bad++; $display("FAIL zero_data: got %h want %h", got, pat); end
      total++;
      if (step_q.size() != 0) begin
        bad++; $display("FAIL zero_steps: got %0d want 0", step_q.size());
      end
      total++;
      if (n_load != N || n_unload != N || n_done != 1) begin
        bad++;
        $display("FAIL zero_counts: got load=%0d unload=%0d done=%0d want %0d/%0d/1",
                 n_load, n_unload, n_done, N, N);
      end
      total++;
      if (rev(chain) !== pat) begin
        bad++; $display("FAIL zero_rotate: got %h want %h", rev(chain), pat);
      end
      total++;
      if (done_busy !== 1'b1) begin
        bad++; $display("FAIL zero_done_busy: got %b want 1", done_busy);
      end
    end
  endtask

  task automatic test_blinker();
    logic [N-1:0] vert, horz;
    vert = '0;
    horz = '0;
    vert[7] = 1'b1; vert[12] = 1'b1; vert[17] = 1'b1;
    horz[11] = 1'b1; horz[12] = 1'b1; horz[13] = 1'b1;
    run_seq(vert, 8'd1, 100, 100, 0);
    total++;
    if (got !== horz) begin bad++; $display("FAIL blinker_data: got %h want %h", got, horz); end
    total++;
    if (step_q.size() != 1) begin
      bad++; $display("FAIL blinker_steps: got %0d want 1", step_q.size());
    end
`ifdef POP_COUNT_EN
    total++;
    if (pop_count !== 3) begin bad++; $display("FAIL blinker_pop: got %0d want 3", pop_count); end
`endif
  endtask

  task automatic test_step_spacing();
    logic [N-1:0] pat;
    pat = rand_pat();
    run_seq(pat, 8'd3, 100, 100, 0);
    total++;
    if (step_q.size() != 3) begin
      bad++; $display("FAIL spacing_count: got %0d want 3", step_q.size());
    end else begin
      total++;
      if (step_q[1] - step_q[0] != STEP_GAP + 1 || step_q[2] - step_q[0] != 2 * (STEP_GAP + 1)) begin
        bad++;
        $display("FAIL spacing_gap: got %0d,%0d want %0d,%0d", step_q[1] - step_q[0],
                 step_q[2] - step_q[0], STEP_GAP + 1, 2 * (STEP_GAP + 1));
      end
      total++;
      if (unload_t - step_q[0] != 3 * (STEP_GAP + 1)) begin
        bad++;
        $display("FAIL spacing_unload: got %0d want %0d", unload_t - step_q[0], 3 * (STEP_GAP + 1));
      end
      total++;
      if (stepg_q[0] !== 3 || stepg_q[1] !== 2 || stepg_q[2] !== 1 || unload_gens !== 0) begin
        bad++;
        $display("FAIL spacing_gens: got %0d,%0d,%0d,%0d want 3,2,1,0", stepg_q[0], stepg_q[1],
                 stepg_q[2], unload_gens);
      end
    end
    total++;
    if (got !== gol_n(pat, 3)) begin
      bad++; $display("FAIL spacing_data: got %h want %h", got, gol_n(pat, 3));
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] pat, exp;
    int g;
    for (int k = 0; k < 4; k++) begin
      pat = rand_pat();
      g   = $urandom_range(3);
      exp = gol_n(pat, g);
      run_seq(pat, GEN_W'(g), 50, 50, 0);
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_data: got %h want %h", got, exp); end
      total++;
      if (shift_viol != 0) begin bad++; $display("FAIL bp_shift_en: got %0d bad cycles want 0", shift_viol); end
      total++;
      if (stall_viol != 0) begin bad++; $display("FAIL bp_stall: got %0d changes want 0", stall_viol); end
      total++;
      if (n_load != N || n_unload != N || step_q.size() != g || timed_out) begin
        bad++;
        $display("FAIL bp_counts: got load=%0d unload=%0d steps=%0d to=%0b want %0d/%0d/%0d/0",
                 n_load, n_unload, step_q.size(), timed_out, N, N, g);
      end
`ifdef POP_COUNT_EN
      total++;
      if (pop_count !== $countones(exp)) begin
        bad++; $display("FAIL bp_pop: got %0d want %0d", pop_count, $countones(exp));
      end
`endif
    end
  endtask

  task automatic test_max_gens();
    logic [N-1:0] pat;
    pat = rand_pat();
    run_seq(pat, 8'hFF, 100, 100, 0);
    total++;
    if (step_q.size() != 255 || timed_out) begin
      bad++; $display("FAIL maxgen_steps: got %0d to=%0b want 255", step_q.size(), timed_out);
    end
    total++;
    if (got !== gol_n(pat, 255)) begin
      bad++; $display("FAIL maxgen_data: got %h want %h", got, gol_n(pat, 255));
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] pat;
    for (int m = 1; m <= 2; m++) begin
      run_seq(rand_pat(), (m == 1) ? 8'd5 : 8'd0, 100, 100, m);
      total++;
      if (!aborted || ab_busy !== 1'b0 || ab_port !== 1'b0) begin
        bad++;
        $display("FAIL abort%0d_idle: got hit=%0b busy=%b port=%b want 1/0/0", m, aborted,
                 ab_busy, ab_port);
      end
      total++;
      if (ab_gens !== 0) begin bad++; $display("FAIL abort%0d_gens: got %0d want 0", m, ab_gens); end
      total++;
      if (n_done != 0) begin bad++; $display("FAIL abort%0d_done: got %0d want 0", m, n_done); end
      pat = rand_pat();
      run_seq(pat, 8'd1, 100, 100, 0);
      total++;
      if (got !== gol(pat) || n_done != 1) begin
        bad++; $display("FAIL abort%0d_rerun: got %h want %h", m, got, gol(pat));
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL start_abort_idle: got busy=%b ready=%b want 0/0", busy, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    int leaks;
    logic [N-1:0] pat;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_gens = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL areset_preload: got ready=%b want 1", bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, shift_en, shift_in, step, busy, done,
         gens_left} !== '0) begin
      bad++;
      $display("FAIL areset_outputs: got ready=%b shift=%b busy=%b gens=%0d want all zero",
               bus.in_ready, shift_en, busy, gens_left);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    leaks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0) leaks++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (leaks != 0) begin bad++; $display("FAIL areset_nostart: got %0d ready cycles want 0", leaks); end
    pat = rand_pat();
    run_seq(pat, 8'd2, 70, 70, 0);
    total++;
    if (got !== gol_n(pat, 2) || n_done != 1) begin
      bad++; $display("FAIL areset_rerun: got %h want %h", got, gol_n(pat, 2));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_gens = '0;
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero_gens();
    test_blinker();
    test_step_spacing();
    test_backpressure();
    test_max_gens();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
